riscv_load_store_unit: RTL and testbench
========================================

Name: riscv_load_store_unit

Overview:
- Data-memory access stage for the MultipleInstructions core. It sits between execute, which issues load/store requests, and a word-organised data memory whose latency may span several cycles.
- Performs byte-lane steering, write-strobe generation, sign/zero extension (LB/LBU/LH/LHU/LW, SB/SH/SW) and a memory-handshake timeout.
- Responses feed the register-file writeback; the assembly bench checks them via x29/x30/x31.

Parameters:
- XLEN, 32, data width; fixed at 32 for RV32I.
- ADDR_WIDTH, 32, byte address width.
- MEM_TIMEOUT_CYCLES, 16, cycles in ACCESS without mem_ack before an error response; must be >= 1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- req_valid  in  1  execute presents a request.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- req_rd  in  5  destination register tag, echoed on the response.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_rd  out  5  echoed tag.
- rsp_err  out  1  illegal funct3, misalignment (optional feature) or timeout.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_WIDTH-2  word address = addr[ADDR_WIDTH-1:2].
- mem_wstrb  out  4  byte write strobes; 0000 on reads.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_ack  in  1  memory completes the access; mem_rdata valid in the same cycle.
- mem_rdata  in  XLEN  full read word.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Encoding comes from the shared package.
- Reset (async, reset==0):
  - State goes to IDLE and the timeout counter clears.
  - All outputs are 0 immediately, except req_ready, which is 1 once reset is released.
  - If reset is asserted mid-ACCESS, mem_req drops at once and no response is ever produced for that request.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge, latch we/funct3/addr/wdata/rd.
  - Legal request: go to ACCESS.
  - Illegal request (funct3 011/110/111, or 100/101 with we=1): go to RESP with err=1 and no memory access.
- ACCESS:
  - req_ready=0 and mem_req=1; mem_we, mem_addr, mem_wstrb and mem_wdata are held stable until ack.
  - Store strobes: B gives 0001<<addr[1:0]; H gives 0011<<{addr[1],0}; W gives 1111.
  - Store data: wdata is replicated into every lane (B: {4{wdata[7:0]}}, H: {2{wdata[15:0]}}).
  - On mem_ack: capture the extracted/extended load data, or 0 for a store, then go to RESP. mem_req is low the next cycle.
  - Timeout: the counter increments each ACCESS cycle without ack. When it reaches MEM_TIMEOUT_CYCLES, go to RESP with err=1 and rdata=0, and drop mem_req. A mem_ack arriving on that same cycle wins over the timeout.
- RESP:
  - rsp_valid=1 for exactly one cycle, together with rdata/rd/err.
  - Then go to IDLE; no backpressure.
- Load extraction:
  - byte = word >> (8*addr[1:0]); half = word >> (16*addr[1]).
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Latency: accept at edge N, mem_req high in cycle N+1. With a zero-wait ack there, rsp_valid is high in cycle N+2. Throughput is one request per 3 cycles minimum.
- Outputs are registered; there is no combinational path from req_* to mem_*.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: an H access with addr[0]=1, or a W access with addr[1:0]!=0, goes IDLE to RESP with err=1, rdata=0, and no memory access.
- Undefined: low address bits are ignored for alignment. H uses addr[1] only; W uses the whole word. The access proceeds with err=0.

Decomposition:
- parameters.vh holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state localparams;
  - the default MEM_TIMEOUT_CYCLES.
- Sub-module lsu_lane_align: combinational; inputs funct3, addr[1:0], wdata and rdata; outputs wstrb, shifted wdata and extended rdata. It is instantiated once and is unit-testable alone.

Test Plan:
- Store/load round trip: SW 0x8000_00F0 to addr 0x100, zero-wait memory. mem_wstrb=1111 and mem_addr=0x40. Then LBU from 0x103 gives rsp_rdata=0x0000_0080, and LB from 0x103 gives 0xFFFF_FF80.
- Halfword lanes: SH 0xBEEF to 0x102. mem_wstrb=1100 and mem_wdata=0xBEEF_BEEF. Then LH 0x102 with mem_rdata=0xBEEF_1234 gives 0xFFFF_BEEF; LHU gives 0x0000_BEEF.
- Wait states: memory acks 5 cycles after mem_req rises. mem_req and mem_addr stay stable for 5 cycles, rsp_valid pulses once, and req_ready=0 throughout.
- Timeout and error cases:
  - No ack at all: rsp_err=1 and rdata=0 exactly 16 ACCESS cycles after mem_req rises; mem_req is low afterwards.
  - funct3=011: err response with mem_req never asserted.
- Reset mid-operation: pull reset low during ACCESS. mem_req=0 immediately and no rsp_valid. After release, an LW of addr 0x0 completes normally.
- Misalignment: LW at 0x102. With LSU_MISALIGN_TRAP_EN, rsp_err=1 and no mem_req. Without it, the access proceeds with word address 0x40 and err=0.

Source files
------------

// File: rtl/riscv_load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM encoding,
// default memory timeout and the request legality check.
package riscv_load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned DEF_MEM_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Unsigned variants only exist for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_load_store_unit_lsu_lane_align.sv
// Combinational byte-lane steering: store strobes, replicated store data and
// sign/zero-extended load data for one 32-bit memory word.
module lsu_lane_align
  import riscv_load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_rdata >> {i_addr_lo, 3'b000});
  assign w_half = 16'(i_rdata >> {i_addr_lo[1], 4'b0000});

  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = 32'd0;
    o_rdata = 32'd0;
    case (i_funct3)
      F3_B: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_byte[7]}}, w_byte};
      end
      F3_BU: o_rdata = {24'd0, w_byte};
      F3_H: begin
        o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_half[15]}}, w_half};
      end
      F3_HU: o_rdata = {16'd0, w_half};
      F3_W: begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_load_store_unit.sv
// Data-memory access stage: IDLE -> ACCESS -> RESP with a handshake timeout.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned H/W accesses into error responses.
module riscv_load_store_unit
  import riscv_load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned MEM_TIMEOUT_CYCLES = DEF_MEM_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_ack,
  input  logic [XLEN-1:0]       mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT_CYCLES + 1);

  lsu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [4:0]       r_rd;

  logic             w_idle;
  logic             w_legal;
  logic             w_misalign;
  logic [2:0]       w_funct3;
  logic [1:0]       w_addr_lo;
  logic [3:0]       w_wstrb;
  logic [XLEN-1:0]  w_wdata_sh;
  logic [XLEN-1:0]  w_rdata_ext;

  assign w_idle    = (r_state == ST_IDLE);
  assign req_ready = w_idle & reset;
  assign w_legal   = f3_legal(req_we, req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                      ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // The aligner steers the incoming store while idle and the latched load afterwards.
  assign w_funct3  = w_idle ? req_funct3    : r_funct3;
  assign w_addr_lo = w_idle ? req_addr[1:0] : r_addr_lo;

  lsu_lane_align u_align (
    .i_funct3  (w_funct3),
    .i_addr_lo (w_addr_lo),
    .i_wdata   (req_wdata),
    .i_rdata   (mem_rdata),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata_sh),
    .o_rdata   (w_rdata_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_funct3  <= 3'b000;
      r_addr_lo <= 2'b00;
      r_rd      <= 5'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_rd    <= 5'd0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_addr_lo <= req_addr[1:0];
            r_rd      <= req_rd;
            if (!w_legal || w_misalign) begin
              r_state   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              rsp_rd    <= req_rd;
            end else begin
              r_state   <= ST_ACCESS;
              r_cnt     <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= req_addr[ADDR_WIDTH-1:2];
              mem_wstrb <= req_we ? w_wstrb : 4'b0000;
              mem_wdata <= req_we ? w_wdata_sh : '0;
            end
          end
        end
        ST_ACCESS: begin
          // An ack on the final timeout cycle still completes the access.
          if (mem_ack || (r_cnt == CNT_W'(MEM_TIMEOUT_CYCLES - 1))) begin
            r_state   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= !mem_ack;
            rsp_rdata <= (mem_ack && !r_we) ? w_rdata_ext : '0;
            rsp_rd    <= r_rd;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_load_store_unit.sv
// Scoreboard bench for riscv_load_store_unit: byte-array reference memory,
// randomized requests, a latency-programmable memory responder and a response monitor.
module tb_riscv_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;

  riscv_load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } mtx_t;

  rsp_t        rsp_q[$];
  mtx_t        mem_q[$];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] dmem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cur_delay = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference load: gather bytes from the byte memory, then extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
    logic [31:0] v;
    int base;
    case (f3)
      3'd0, 3'd4: begin
        v = 32'(ref_mem[a]);
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        base = a - a % 2;
        v = 32'(ref_mem[base]) + 32'd256 * 32'(ref_mem[base+1]);
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: begin
        base = a - a % 4;
        v = 32'(ref_mem[base]) + 32'd256 * 32'(ref_mem[base+1]) +
            32'd65536 * 32'(ref_mem[base+2]) + 32'd16777216 * 32'(ref_mem[base+3]);
      end
    endcase
    return v;
  endfunction

  // Reference store: strobe bit = lane of every byte the store touches.
  function automatic logic [3:0] ref_store(input logic [2:0] f3, input int a,
                                           input logic [31:0] wd, input bit commit);
    int base, n;
    logic [3:0] s;
    s = 4'b0000;
    case (f3)
      3'd0:    begin base = a;         n = 1; end
      3'd1:    begin base = a - a % 2; n = 2; end
      default: begin base = a - a % 4; n = 4; end
    endcase
    for (int i = 0; i < n; i++) begin
      if (commit) ref_mem[base+i] = wd[8*i +: 8];
      s[(base+i) % 4] = 1'b1;
    end
    return s;
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input int a,
                       input logic [31:0] wd, input logic [4:0] rd, input int d);
    int   n;
    int   c;
    logic legal, mis;
    rsp_t r;
    mtx_t m;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: req_ready %b after %0d cycles, expected 1", req_ready, n);
      return;
    end
    cur_delay  = d;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = 32'(a);
    req_wdata  = wd;
    req_rd     = rd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    c = cyc;
    legal = !(f3 == 3'd3 || f3 >= 3'd6 || (we && (f3 == 3'd4 || f3 == 3'd5)));
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) || (f3 == 3'd2 && (a % 4 != 0));
`endif
    r.rd = rd;
    r.rdata = 32'd0;
    r.err = 1'b0;
    r.cyc = c;
    if (!legal || mis) begin
      r.err = 1'b1;
    end else begin
      m.we = we;
      m.addr = 30'(a / 4);
      m.strb = 4'b0000;
      m.wdata = 32'd0;
      if (we) begin
        m.wdata = (f3 == 3'd0) ? {4{wd[7:0]}} : (f3 == 3'd1) ? {2{wd[15:0]}} : wd;
        m.strb = ref_store(f3, a, wd, d <= TO);
      end
      if (d <= TO) begin
        r.cyc = c + d;
        if (!we) r.rdata = ref_load(f3, a);
      end else begin
        r.err = 1'b1;
        r.cyc = c + TO;
      end
      mem_q.push_back(m);
    end
    rsp_q.push_back(r);
  endtask

  // Memory responder: checks each access, holds it stable, acks in cycle cur_delay.
  initial begin
    int   k;
    mtx_t m;
    mtx_t cap;
    k = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset || !mem_req) begin
        k = 0;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end else begin
        k++;
        if (k == 1) begin
          if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected: mem_req=1 addr %h, expected no access", mem_addr);
          end else begin
            m = mem_q.pop_front();
            chk("mem_we", 32'(mem_we), 32'(m.we));
            chk("mem_addr", 32'(mem_addr), 32'(m.addr));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(m.strb));
            if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
          end
          cap = {mem_we, mem_addr, mem_wstrb, mem_wdata};
        end else begin
          chk("mem_addr_hold", 32'(mem_addr), 32'(cap.addr));
          chk("mem_ctl_hold", 32'({mem_we, mem_wstrb}), 32'({cap.we, cap.strb}));
          chk("mem_wdata_hold", mem_wdata, cap.wdata);
        end
        if (k == cur_delay) begin
          mem_ack = 1'b1;
          mem_rdata = dmem[mem_addr[7:0]];
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) dmem[mem_addr[7:0]][8*b +: 8] = mem_wdata[8*b +: 8];
          end
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Response monitor: ready must track "nothing outstanding"; responses pop the scoreboard.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("req_ready", 32'(req_ready), 32'(rsp_q.size() == 0));
        if (rsp_valid) begin
          if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: rsp_valid=1 rd %0d, expected no response", rsp_rd);
          end else begin
            r = rsp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, r.rdata);
            chk("rsp_rd", 32'(rsp_rd), 32'(r.rd));
            chk("rsp_err", 32'(rsp_err), 32'(r.err));
            chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
          end
        end
      end
    end
  end

  initial begin
    int n, r, d;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    for (int i = 0; i < 256; i++) begin
      dmem[i] = $urandom;
      for (int j = 0; j < 4; j++) ref_mem[4*i+j] = dmem[i][8*j +: 8];
    end

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    #2 reset = 1'b1;
    #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Round trip, halfword lanes, wait states
    issue(1'b1, 3'd2, 'h100, 32'h8000_00F0, 5'd1, 1);
    issue(1'b0, 3'd4, 'h103, 32'd0, 5'd2, 1);
    issue(1'b0, 3'd0, 'h103, 32'd0, 5'd3, 1);
    issue(1'b1, 3'd1, 'h102, 32'h0000_BEEF, 5'd4, 1);
    issue(1'b0, 3'd1, 'h102, 32'd0, 5'd5, 1);
    issue(1'b0, 3'd5, 'h102, 32'd0, 5'd6, 1);
    issue(1'b0, 3'd2, 'h104, 32'd0, 5'd7, 6);
    // Timeout, ack on the last allowed cycle, and a timed-out store that must not write
    issue(1'b0, 3'd2, 'h108, 32'd0, 5'd8, 1000);
    issue(1'b1, 3'd2, 'h10C, 32'h1234_5678, 5'd9, TO);
    issue(1'b0, 3'd2, 'h10C, 32'd0, 5'd10, 1);
    issue(1'b1, 3'd2, 'h10C, 32'hDEAD_BEEF, 5'd11, TO + 1);
    issue(1'b0, 3'd2, 'h10C, 32'd0, 5'd12, 1);
    // Illegal encodings and misaligned accesses
    issue(1'b0, 3'd3, 'h110, 32'd0, 5'd13, 1);
    issue(1'b1, 3'd4, 'h110, 32'hFF, 5'd14, 1);
    issue(1'b0, 3'd7, 'h110, 32'd0, 5'd15, 1);
    issue(1'b0, 3'd2, 'h102, 32'd0, 5'd16, 1);
    issue(1'b0, 3'd1, 'h103, 32'd0, 5'd17, 2);

    // Reset in the middle of an access
    issue(1'b0, 3'd2, 'h40, 32'd0, 5'd20, 1000);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    rsp_q.delete();
    mem_q.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("midrst_ready", 32'(req_ready), 32'd1);
    issue(1'b0, 3'd2, 'h0, 32'd0, 5'd21, 1);

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 19);
      if (r < 14)       d = $urandom_range(1, 4);
      else if (r < 17)  d = $urandom_range(5, TO);
      else if (r == 17) d = TO;
      else if (r == 18) d = TO + 1;
      else              d = 1000;
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 1023),
            $urandom, 5'($urandom_range(0, 31)), d);
    end

    n = 0;
    while (rsp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
